// File: rtl/lsu_bytelane.sv
// Load-store unit with byte/halfword/word access to a synchronous-read data
// memory and a memory-mapped IO page. Accepts one request per cycle; load
// and error responses appear one cycle after acceptance.
module lsu_bytelane #(
    parameter int unsigned DMEM_AW     = 11,
    parameter logic [31:0] DMEM_BASE   = 32'h0000_2000,
    parameter logic [31:0] IO_BASE     = 32'h0000_7000,
    parameter int unsigned N_HEX       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic               i_lsu_wren,
    input  logic [31:0]        i_lsu_addr,
    input  logic [2:0]         i_funct3,
    input  logic [31:0]        i_st_data,
    output logic               o_ld_valid,
    output logic [31:0]        o_ld_data,
    output logic               o_err,
    output logic [31:0]        o_io_ledr,
    output logic [31:0]        o_io_ledg,
    output logic [7*N_HEX-1:0] o_io_hex,
    output logic [31:0]        o_io_lcd,
    input  logic [31:0]        i_io_sw,
    input  logic [3:0]         i_io_btn
);

    localparam int unsigned DEPTH = 2 ** DMEM_AW;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // IO page word offsets (byte offset >> 2)
    localparam logic [9:0] OFF_LEDR = 10'h000;
    localparam logic [9:0] OFF_LEDG = 10'h004;
    localparam logic [9:0] OFF_HEXL = 10'h008;
    localparam logic [9:0] OFF_HEXH = 10'h009;
    localparam logic [9:0] OFF_LCD  = 10'h00C;
    localparam logic [9:0] OFF_SW   = 10'h200;
    localparam logic [9:0] OFF_BTN  = 10'h204;

    localparam logic [1:0] SRC_ZERO = 2'd0;
    localparam logic [1:0] SRC_DMEM = 2'd1;
    localparam logic [1:0] SRC_IO   = 2'd2;

    logic [31:0]        r_mem [0:DEPTH-1];
    logic [31:0]        r_dmem_q;
    logic [31:0]        r_io_q;
    logic [31:0]        r_ledr, r_ledg, r_hexl, r_hexh, r_lcd;
    logic [31:0]        r_sw_sync  [0:SYNC_STAGES-1];
    logic [3:0]         r_btn_sync [0:SYNC_STAGES-1];
    logic               r_ld_valid, r_err;
    logic [1:0]         r_src;
    logic [1:0]         r_off;
    logic [2:0]         r_f3;

    logic               w_dmem_hit, w_io_hit;
    logic [9:0]         w_io_off;
    logic [DMEM_AW-1:0] w_dmem_idx;
    logic               w_misalign, w_f3_bad, w_err;
    logic               w_st_ok, w_ld_ok;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_io_rdata;
    logic [31:0]        w_word, w_shift, w_ext;

    // Merge enabled byte lanes of new data into an existing word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    assign w_dmem_hit = (i_lsu_addr[31:DMEM_AW+2] == DMEM_BASE[31:DMEM_AW+2]);
    assign w_io_hit   = (i_lsu_addr[31:12] == IO_BASE[31:12]);
    assign w_io_off   = i_lsu_addr[11:2];
    assign w_dmem_idx = i_lsu_addr[DMEM_AW+1:2];

    // Request decode: alignment, legality, byte enables and lane replication
    always_comb begin
        w_misalign = 1'b0;
        w_f3_bad   = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = i_st_data;
        case (i_funct3)
            F3_H, F3_HU: w_misalign = i_lsu_addr[0];
            F3_W:        w_misalign = |i_lsu_addr[1:0];
            default:     w_misalign = 1'b0;
        endcase
        if (i_lsu_wren) begin
            w_f3_bad = !((i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W));
        end else begin
            w_f3_bad = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
        end
        case (i_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_lsu_addr[1:0];
                w_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                w_be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_st_data;
            end
        endcase
    end

    assign w_err   = w_misalign | w_f3_bad;
    assign w_st_ok = i_req & i_lsu_wren & ~w_err & ~i_rst;
    assign w_ld_ok = i_req & ~i_lsu_wren & ~w_err;

    // IO read mux over registers and synchronised inputs
    always_comb begin
        w_io_rdata = 32'd0;
        case (w_io_off)
            OFF_LEDR: w_io_rdata = r_ledr;
            OFF_LEDG: w_io_rdata = r_ledg;
            OFF_HEXL: w_io_rdata = r_hexl;
            OFF_HEXH: w_io_rdata = r_hexh;
            OFF_LCD:  w_io_rdata = r_lcd;
            OFF_SW:   w_io_rdata = r_sw_sync[SYNC_STAGES-1];
            OFF_BTN:  w_io_rdata = 32'(r_btn_sync[SYNC_STAGES-1]);
            default:  w_io_rdata = 32'd0;
        endcase
    end

    // Data memory: byte-lane write, synchronous read (contents not reset)
    always_ff @(posedge i_clk) begin
        if (w_st_ok && w_dmem_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_dmem_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
        if (i_req && !i_lsu_wren) begin
            r_dmem_q <= r_mem[w_dmem_idx];
        end
    end

    // Writable IO registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ledr <= 32'd0;
            r_ledg <= 32'd0;
            r_hexl <= 32'd0;
            r_hexh <= 32'd0;
            r_lcd  <= 32'd0;
        end else if (w_st_ok && w_io_hit) begin
            case (w_io_off)
                OFF_LEDR: r_ledr <= merge_bytes(r_ledr, w_wdata, w_be);
                OFF_LEDG: r_ledg <= merge_bytes(r_ledg, w_wdata, w_be);
                OFF_HEXL: r_hexl <= merge_bytes(r_hexl, w_wdata, w_be);
                OFF_HEXH: r_hexh <= merge_bytes(r_hexh, w_wdata, w_be);
                OFF_LCD:  r_lcd  <= merge_bytes(r_lcd,  w_wdata, w_be);
                default: ;
            endcase
        end
    end

    // Synchronisers for asynchronous switch and button inputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                r_sw_sync[s]  <= 32'd0;
                r_btn_sync[s] <= 4'd0;
            end
        end else begin
            r_sw_sync[0]  <= i_io_sw;
            r_btn_sync[0] <= i_io_btn;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                r_sw_sync[s]  <= r_sw_sync[s-1];
                r_btn_sync[s] <= r_btn_sync[s-1];
            end
        end
    end

    // Response stage: remember what the accepted request needs for extension
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ld_valid <= 1'b0;
            r_err      <= 1'b0;
            r_src      <= SRC_ZERO;
            r_off      <= 2'd0;
            r_f3       <= 3'd0;
            r_io_q     <= 32'd0;
        end else begin
            r_ld_valid <= i_req & ~i_lsu_wren;
            r_err      <= i_req & w_err;
            r_off      <= i_lsu_addr[1:0];
            r_f3       <= i_funct3;
            if (!w_ld_ok)        r_src <= SRC_ZERO;
            else if (w_dmem_hit) r_src <= SRC_DMEM;
            else if (w_io_hit)   r_src <= SRC_IO;
            else                 r_src <= SRC_ZERO;
            if (w_ld_ok) r_io_q <= w_io_rdata;
        end
    end

    // Lane shift and sign/zero extension of the returned word
    always_comb begin
        w_word = 32'd0;
        case (r_src)
            SRC_DMEM: w_word = r_dmem_q;
            SRC_IO:   w_word = r_io_q;
            default:  w_word = 32'd0;
        endcase
        w_shift = w_word >> {r_off, 3'b000};
        case (r_f3)
            F3_B:    w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_BU:   w_ext = {24'd0, w_shift[7:0]};
            F3_HU:   w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    assign o_ld_valid = r_ld_valid;
    assign o_err      = r_err;
    assign o_ld_data  = r_ld_valid ? w_ext : 32'd0;
    assign o_io_ledr  = r_ledr;
    assign o_io_ledg  = r_ledg;
    assign o_io_lcd   = r_lcd;

    // Seven-segment digits: low four from HEXL bytes, upper four from HEXH bytes
    for (genvar g = 0; g < int'(N_HEX); g++) begin : g_hex
        if (g < 4) begin : g_lo
            assign o_io_hex[7*g +: 7] = r_hexl[8*g +: 7];
        end else begin : g_hi
            assign o_io_hex[7*g +: 7] = r_hexh[8*(g-4) +: 7];
        end
    end

endmodule

// File: tb/tb_lsu_bytelane.sv
// Scoreboard bench for lsu_bytelane: directed requests push expected
// responses; a negedge monitor compares them in the cycle they are due.
module tb_lsu_bytelane;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned N_HEX       = 8;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req = 1'b0;
    logic               wren = 1'b0;
    logic [31:0]        addr = 32'd0;
    logic [2:0]         f3 = 3'd0;
    logic [31:0]        sdata = 32'd0;
    logic               ld_valid, err;
    logic [31:0]        ld_data;
    logic [31:0]        ledr, ledg, lcd;
    logic [7*N_HEX-1:0] hex;
    logic [31:0]        sw = 32'd0;
    logic [3:0]         btn = 4'd0;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    typedef struct {
        int unsigned due;
        logic        v;
        logic        e;
        logic [31:0] d;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    lsu_bytelane #(
        .DMEM_AW(11), .DMEM_BASE(32'h0000_2000), .IO_BASE(32'h0000_7000),
        .N_HEX(N_HEX), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_lsu_wren(wren),
        .i_lsu_addr(addr), .i_funct3(f3), .i_st_data(sdata),
        .o_ld_valid(ld_valid), .o_ld_data(ld_data), .o_err(err),
        .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd),
        .i_io_sw(sw), .i_io_btn(btn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: compare the due response, flag any unexpected one
    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            x = sb_q.pop_front();
            checks++;
            if (ld_valid !== x.v || err !== x.e || ld_data !== x.d) begin
                failures++;
                $display("FAIL %s: got valid=%0b err=%0b data=%08h, want valid=%0b err=%0b data=%08h",
                         x.name, ld_valid, err, ld_data, x.v, x.e, x.d);
            end
        end else if (ld_valid !== 1'b0 || err !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: got valid=%0b err=%0b data=%08h, want valid=0 err=0",
                     ld_valid, err, ld_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] sd, input logic ev, input logic ee,
                         input logic [31:0] ed, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        req = 1'b1; wren = w; addr = a; f3 = f; sdata = sd;
        x.due = cyc + 1; x.v = ev; x.e = ee; x.d = ed; x.name = nm;
        sb_q.push_back(x);
    endtask

    task automatic st(input logic [31:0] a, input logic [2:0] f, input logic [31:0] sd,
                      input string nm);
        issue(1'b1, a, f, sd, 1'b0, 1'b0, 32'd0, nm);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] f, input logic [31:0] ed,
                      input string nm);
        issue(1'b0, a, f, 32'd0, 1'b1, 1'b0, ed, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req = 1'b0; wren = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ld_valid), 64'd0);
        chk("rst_err",   64'(err),      64'd0);
        chk("rst_data",  64'(ld_data),  64'd0);
        chk("rst_ledr",  64'(ledr),     64'd0);
        chk("rst_hex",   64'(hex),      64'd0);
        rst = 1'b0;
        ld(32'h7000, LW, 32'h0, "ledr_after_rst");

        // Sub-word stores and loads
        st(32'h2000, LW, 32'h8899_AABB, "sw_2000");
        st(32'h2001, LB, 32'h0000_0012, "sb_2001");
        ld(32'h2000, LW,  32'h8899_12BB, "lw_2000");
        ld(32'h2003, LB,  32'hFFFF_FF88, "lb_2003");
        ld(32'h2003, LBU, 32'h0000_0088, "lbu_2003");
        ld(32'h2002, LH,  32'hFFFF_8899, "lh_2002");
        ld(32'h2000, LHU, 32'h0000_12BB, "lhu_2000");

        // Misaligned and illegal accesses
        issue(1'b0, 32'h2002, LW, 32'd0, 1'b1, 1'b1, 32'd0, "lw_misalign");
        issue(1'b1, 32'h2001, LH, 32'h0000_FFFF, 1'b0, 1'b1, 32'd0, "sh_misalign");
        issue(1'b0, 32'h2000, 3'b011, 32'd0, 1'b1, 1'b1, 32'd0, "ld_f3_011");
        issue(1'b1, 32'h2000, 3'b100, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, "st_f3_100");
        ld(32'h2000, LW, 32'h8899_12BB, "lw_2000_unchanged");

        // Back-to-back store then load of the same word
        st(32'h2010, LW, 32'hDEAD_BEEF, "sw_2010");
        ld(32'h2010, LW, 32'hDEAD_BEEF, "lw_2010_b2b");
        st(32'h2012, LH, 32'h0000_1234, "sh_2012");
        ld(32'h2012, LH,  32'h0000_1234, "lh_2012");
        ld(32'h2010, LB,  32'hFFFF_FFEF, "lb_2010");
        ld(32'h2011, LBU, 32'h0000_00BE, "lbu_2011");
        ld(32'h2010, LW,  32'h1234_BEEF, "lw_2010_merged");

        // IO registers
        st(32'h7020, LW, 32'h4079_2430, "sw_hexl");
        st(32'h7025, LB, 32'h0000_0012, "sb_hexh1");
        st(32'h7010, LW, 32'h0000_00FF, "sw_ledg");
        st(32'h7013, LB, 32'h0000_0080, "sb_ledg3");
        st(32'h7030, LW, 32'h1234_5678, "sw_lcd");
        st(32'h7800, LW, 32'hFFFF_FFFF, "sw_to_switch");
        idle(1);
        chk("hex_d0", 64'(hex[6:0]),   64'h30);
        chk("hex_d1", 64'(hex[13:7]),  64'h24);
        chk("hex_d3", 64'(hex[27:21]), 64'h40);
        chk("hex_d5", 64'(hex[41:35]), 64'h12);
        chk("ledg",   64'(ledg),       64'h8000_00FF);
        chk("lcd",    64'(lcd),        64'h1234_5678);
        ld(32'h7012, LH, 32'hFFFF_8000, "lh_ledg_hi");
        ld(32'h7024, LW, 32'h0000_1200, "lw_hexh");
        ld(32'h7800, LW, 32'h0000_0000, "lw_sw_ignored_store");
        ld(32'h7004, LW, 32'h0000_0000, "lw_io_unmapped");

        // Synchronised switch input latency
        issue(1'b0, 32'h7800, LW, 32'd0, 1'b1, 1'b0, 32'h0, "lw_sw_now");
        sw = 32'h0000_00A5;
        ld(32'h7800, LW, 32'h0000_0000, "lw_sw_plus1");
        ld(32'h7800, LW, 32'h0000_00A5, "lw_sw_plus2");
        btn = 4'hA;
        idle(SYNC_STAGES + 1);
        ld(32'h7810, LW, 32'h0000_000A, "lw_btn");

        // Boundary and unmapped dmem accesses
        st(32'h3FFC, LW, 32'hCAFE_F00D, "sw_last");
        ld(32'h3FFC, LW, 32'hCAFE_F00D, "lw_last");
        ld(32'h4000, LW, 32'h0000_0000, "lw_unmapped");
        st(32'h4000, LW, 32'h1111_1111, "sw_unmapped");
        ld(32'h2000, LW, 32'h8899_12BB, "lw_2000_after_unmapped");
        idle(2);

        // Reset in the middle of a load
        st(32'h7000, LW, 32'h0000_0055, "sw_ledr");
        ld(32'h2000, LW, 32'h8899_12BB, "lw_before_rst");
        @(posedge clk);
        #2;
        rst = 1'b1; req = 1'b0;
        sb_q.delete();
        #1;
        chk("midrst_valid", 64'(ld_valid), 64'd0);
        chk("midrst_ledr",  64'(ledr),     64'd0);
        chk("midrst_hex",   64'(hex),      64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        ld(32'h7000, LW, 32'h0000_0000, "ledr_after_midrst");
        idle(3);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
